// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with init walk, write bypass and pending-write scoreboard.
// Optional debug read port and write-collision flag enabled by REGFILE_DBG_PORT_EN.
module regfile_mp #(
  parameter int WIDTH      = 64,
  parameter int DEPTH      = 32,
  parameter int NUM_RD     = 2,
  parameter int ZERO_REG   = 1,
  parameter int INIT_INDEX = 1,
  localparam int ADDR_W    = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*WIDTH-1:0]  rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     wr0_en,
  input  logic [ADDR_W-1:0]        wr0_addr,
  input  logic [WIDTH-1:0]         wr0_data,
  input  logic                     wr1_en,
  input  logic [ADDR_W-1:0]        wr1_addr,
  input  logic [WIDTH-1:0]         wr1_data,
  input  logic                     alloc_en,
  input  logic [ADDR_W-1:0]        alloc_addr,
  output logic                     ready
`ifdef REGFILE_DBG_PORT_EN
  ,
  input  logic [ADDR_W-1:0]        dbg_addr,
  output logic [WIDTH-1:0]         dbg_data,
  output logic                     wr_collision
`endif
);
  typedef enum logic {S_INIT, S_RUN} state_t;
  state_t              r_state;
  logic [ADDR_W-1:0]   r_init_cnt;
  logic [WIDTH-1:0]    r_mem [DEPTH];
  logic [DEPTH-1:0]    r_busy;
  logic [DEPTH-1:0]    w_busy_nxt;
  logic                w_run;
  logic                w_we0;
  logic                w_we1;
  logic [WIDTH-1:0]    w_init_val;
  assign w_run      = (r_state == S_RUN) && !reset;
  assign w_we0      = wr0_en && !(ZERO_REG != 0 && wr0_addr == '0);
  assign w_we1      = wr1_en && !(ZERO_REG != 0 && wr1_addr == '0);
  assign w_init_val = (INIT_INDEX != 0) ? WIDTH'(r_init_cnt) : '0;
  assign ready      = w_run;
  // Allocation is applied after the write clears so a new producer stays pending.
  always_comb begin
    w_busy_nxt = r_busy;
    if (wr0_en) w_busy_nxt[wr0_addr] = 1'b0;
    if (wr1_en) w_busy_nxt[wr1_addr] = 1'b0;
    if (alloc_en && !(ZERO_REG != 0 && alloc_addr == '0)) w_busy_nxt[alloc_addr] = 1'b1;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_INIT;
      r_init_cnt <= '0;
      r_busy     <= '0;
    end else if (r_state == S_INIT) begin
      r_mem[r_init_cnt] <= w_init_val;
      r_init_cnt        <= r_init_cnt + 1'b1;
      if (r_init_cnt == ADDR_W'(DEPTH - 1)) r_state <= S_RUN;
    end else begin
      if (w_we0) r_mem[wr0_addr] <= wr0_data;
      if (w_we1) r_mem[wr1_addr] <= wr1_data;
      r_busy <= w_busy_nxt;
    end
  end
  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] w_a;
    logic              w_hit0;
    logic              w_hit1;
    logic              w_zero;
    assign w_a    = rd_addr[k*ADDR_W +: ADDR_W];
    assign w_hit0 = wr0_en && wr0_addr == w_a;
    assign w_hit1 = wr1_en && wr1_addr == w_a;
    assign w_zero = ZERO_REG != 0 && w_a == '0;
    assign rd_data[k*WIDTH +: WIDTH] = (!w_run || w_zero) ? '0 :
                                       w_hit1 ? wr1_data :
                                       w_hit0 ? wr0_data : r_mem[w_a];
    assign rd_busy[k] = w_run && r_busy[w_a] && !(w_hit0 || w_hit1);
  end
`ifdef REGFILE_DBG_PORT_EN
  assign dbg_data     = w_run ? r_mem[dbg_addr] : '0;
  assign wr_collision = w_run && wr0_en && wr1_en && wr0_addr == wr1_addr && wr0_addr != '0;
`endif
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: randomized and directed scoreboard bench for regfile_mp against an array-level model.
module tb_regfile_mp;
  localparam int W  = 64;
  localparam int D  = 32;
  localparam int AW = 5;
  localparam int NR = 2;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset = 1'b1;
  logic [NR*AW-1:0] rd_addr = '0;
  logic [NR*W-1:0]  rd_data;
  logic [NR-1:0]    rd_busy;
  logic wr0_en = 1'b0, wr1_en = 1'b0, alloc_en = 1'b0;
  logic [AW-1:0] wr0_addr = '0, wr1_addr = '0, alloc_addr = '0, dbg_a = '0;
  logic [W-1:0] wr0_data = '0, wr1_data = '0;
  logic ready;
`ifdef REGFILE_DBG_PORT_EN
  logic [W-1:0] dbg_data;
  logic wr_collision;
`endif
  regfile_mp dut (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
    .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
    .alloc_en(alloc_en), .alloc_addr(alloc_addr), .ready(ready)
`ifdef REGFILE_DBG_PORT_EN
    , .dbg_addr(dbg_a), .dbg_data(dbg_data), .wr_collision(wr_collision)
`endif
  );
  typedef struct packed {
    logic [NR*W-1:0] d;
    logic [NR-1:0]   b;
    logic            r;
    logic [W-1:0]    dd;
    logic            c;
  } exp_t;
  exp_t q[$];
  exp_t mon_e;
  logic [W-1:0] m_mem [D];
  bit           m_busy [D];
  int           m_left = D;
  int checks = 0, errors = 0;
  task automatic chk(input string name, input logic [NR*W-1:0] act, input logic [NR*W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask
  // One clock of stimulus: expected outputs for this cycle are queued, then the model takes the edge.
  task automatic cyc(input logic rs, input logic e0, input logic [AW-1:0] a0, input logic [W-1:0] d0,
                     input logic e1, input logic [AW-1:0] a1, input logic [W-1:0] d1,
                     input logic ea, input logic [AW-1:0] aa,
                     input logic [AW-1:0] r0, input logic [AW-1:0] r1, input logic [AW-1:0] da);
    exp_t e;
    bit run;
    logic [AW-1:0] a;
    logic [W-1:0] v;
    bit bz;
    @(posedge clk);
    #1;
    reset = rs; wr0_en = e0; wr0_addr = a0; wr0_data = d0;
    wr1_en = e1; wr1_addr = a1; wr1_data = d1;
    alloc_en = ea; alloc_addr = aa; rd_addr = {r1, r0}; dbg_a = da;
    run = !rs && m_left == 0;
    e = '0;
    e.r = run;
    for (int k = 0; k < NR; k++) begin
      a = (k == 0) ? r0 : r1;
      v = m_mem[a];
      bz = m_busy[a];
      if (e0 && a0 == a) begin v = d0; bz = 0; end
      if (e1 && a1 == a) begin v = d1; bz = 0; end
      if (a == 0) v = '0;
      if (!run) begin v = '0; bz = 0; end
      e.d[k*W +: W] = v;
      e.b[k] = bz;
    end
    e.dd = run ? m_mem[da] : '0;
    e.c = run && e0 && e1 && a0 == a1 && a0 != 0;
    q.push_back(e);
    if (rs) begin
      m_left = D;
      for (int i = 0; i < D; i++) begin m_mem[i] = W'(i); m_busy[i] = 0; end
    end else if (m_left > 0) begin
      m_left--;
    end else begin
      if (e0 && a0 != 0) m_mem[a0] = d0;
      if (e1 && a1 != 0) m_mem[a1] = d1;
      if (e0) m_busy[a0] = 0;
      if (e1) m_busy[a1] = 0;
      if (ea && aa != 0) m_busy[aa] = 1;
    end
  endtask
  task automatic idle(input int n, input logic [AW-1:0] r0, input logic [AW-1:0] r1);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, r0, r1, r0);
  endtask
  function automatic logic [AW-1:0] raddr();
    return ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 9)) : AW'($urandom_range(0, D - 1));
  endfunction
  always @(negedge clk) begin
    if (q.size() != 0) begin
      mon_e = q.pop_front();
      chk("rd_data", rd_data, mon_e.d);
      chk("rd_busy", {{(NR*W-NR){1'b0}}, rd_busy}, {{(NR*W-NR){1'b0}}, mon_e.b});
      chk("ready", {{(NR*W-1){1'b0}}, ready}, {{(NR*W-1){1'b0}}, mon_e.r});
`ifdef REGFILE_DBG_PORT_EN
      chk("dbg_data", {{(NR*W-W){1'b0}}, dbg_data}, {{(NR*W-W){1'b0}}, mon_e.dd});
      chk("wr_collision", {{(NR*W-1){1'b0}}, wr_collision}, {{(NR*W-1){1'b0}}, mon_e.c});
`endif
    end
  end
  initial begin
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 7, 31, 12);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 7, 31, 12);
    idle(34, 7, 31);
    cyc(0, 1, 5, 64'hAAAA, 1, 5, 64'h5555, 0, 0, 5, 6, 5);
    idle(2, 5, 6);
    cyc(0, 1, 0, '1, 0, 0, 0, 1, 0, 0, 0, 0);
    idle(2, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 9, 9, 8, 9);
    idle(2, 9, 8);
    cyc(0, 1, 9, 64'h1234, 0, 0, 0, 0, 0, 9, 8, 9);
    idle(1, 9, 8);
    cyc(0, 0, 0, 0, 1, 9, 64'h77, 1, 9, 9, 8, 9);
    idle(2, 9, 8);
    cyc(0, 1, 12, 64'h1, 1, 12, 64'h2, 0, 0, 12, 3, 12);
    idle(2, 12, 3);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 3, 12, 3);
    idle(10, 3, 12);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 3, 12, 3);
    for (int i = 0; i < 32; i++) cyc(0, 1, 3, 64'hBEEF, 0, 0, 0, 1, 3, 3, 12, 3);
    idle(3, 3, 12);
    for (int i = 0; i < 800; i++)
      cyc($urandom_range(0, 299) == 0, $urandom_range(0, 1) == 1, raddr(), {$urandom, $urandom},
          $urandom_range(0, 1) == 1, raddr(), {$urandom, $urandom},
          $urandom_range(0, 2) == 0, raddr(), raddr(), raddr(), raddr());
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: %0d entries left, expected 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
